// File: rtl/posit_stft_framer.sv
// Collects complex samples into 4-sample frames for a 4-point FFT with valid/ready on both sides.
// Define STFT_OVERLAP_EN for 50% overlap (hop 2); the default build uses disjoint frames (hop 4).
module posit_stft_framer #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_re,
  input  logic [DATA_W-1:0] s_im,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic [DATA_W-1:0] re_x0,
  output logic [DATA_W-1:0] re_x1,
  output logic [DATA_W-1:0] re_x2,
  output logic [DATA_W-1:0] re_x3,
  output logic [DATA_W-1:0] im_x0,
  output logic [DATA_W-1:0] im_x1,
  output logic [DATA_W-1:0] im_x2,
  output logic [DATA_W-1:0] im_x3,
  output logic [CNT_W-1:0]  frame_count
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t            r_state;
  logic [2:0]        r_count;
  logic [DATA_W-1:0] r_re [4];
  logic [DATA_W-1:0] r_im [4];
  logic              r_frame_valid;
  logic              r_s_ready;
  logic [CNT_W-1:0]  r_frame_count;

  logic w_s_acc;
  logic w_f_acc;

  assign w_s_acc = s_valid & r_s_ready;
  assign w_f_acc = r_frame_valid & frame_ready;

  // Handshake flags are kept as registers so they are never both high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FILL;
      r_count       <= 3'd0;
      r_frame_valid <= 1'b0;
      r_s_ready     <= 1'b1;
      r_frame_count <= '0;
      for (int i = 0; i < 4; i++) begin
        r_re[i] <= '0;
        r_im[i] <= '0;
      end
    end else if (flush) begin
      r_state       <= FILL;
      r_count       <= 3'd0;
      r_frame_valid <= 1'b0;
      r_s_ready     <= 1'b1;
      r_frame_count <= '0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_s_acc) begin
            r_re[r_count[1:0]] <= s_re;
            r_im[r_count[1:0]] <= s_im;
            if (r_count == 3'd3) begin
              r_state       <= HOLD;
              r_count       <= 3'd4;
              r_frame_valid <= 1'b1;
              r_s_ready     <= 1'b0;
            end else begin
              r_count <= r_count + 3'd1;
            end
          end
        end
        HOLD: begin
          if (w_f_acc) begin
            r_state       <= FILL;
            r_frame_valid <= 1'b0;
            r_s_ready     <= 1'b1;
            r_frame_count <= r_frame_count + 1'b1;
`ifdef STFT_OVERLAP_EN
            // Newest half of the frame becomes the oldest half of the next one.
            r_re[0] <= r_re[2];
            r_re[1] <= r_re[3];
            r_im[0] <= r_im[2];
            r_im[1] <= r_im[3];
            r_count <= 3'd2;
`else
            r_count <= 3'd0;
`endif
          end
        end
      endcase
    end
  end

  assign s_ready     = r_s_ready;
  assign frame_valid = r_frame_valid;
  assign frame_count = r_frame_count;
  assign re_x0 = r_re[0];
  assign re_x1 = r_re[1];
  assign re_x2 = r_re[2];
  assign re_x3 = r_re[3];
  assign im_x0 = r_im[0];
  assign im_x1 = r_im[1];
  assign im_x2 = r_im[2];
  assign im_x3 = r_im[3];

endmodule

// File: doc/posit_stft_framer.md
POSIT_STFT_FRAMER -- requirements
Module: posit_stft_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the width of each real or imaginary posit/float word.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of the frame counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous restart of framing.
REQ-006 SHALL have port s_valid, input, 1 bit: an input sample is offered.
REQ-007 SHALL have port s_ready, output, 1 bit: the framer can accept a sample.
REQ-008 SHALL have ports s_re and s_im, input, DATA_W bits each: the real and imaginary parts of the sample.
REQ-009 SHALL have port frame_valid, output, 1 bit: a complete 4-sample frame is presented; it drives the 4-point FFT valid_in.
REQ-010 SHALL have port frame_ready, input, 1 bit: the downstream consumer accepts the frame.
REQ-011 SHALL have ports re_x0..re_x3 and im_x0..im_x3, output, DATA_W bits each: the frame samples, with x0 the oldest and x3 the newest.
REQ-012 SHALL have port frame_count, output, CNT_W bits: the number of frames accepted since reset or flush.

Function
REQ-013 SHALL keep a 4-entry complex sample register plus a fill count of 0..4.
REQ-014 SHALL implement two states, FILL and HOLD, with reset state FILL.
REQ-015 In FILL, s_ready SHALL be 1; in HOLD, s_ready SHALL be 0.
REQ-016 A sample is accepted when s_valid and s_ready are both 1; on acceptance it SHALL be written to slot x[count] and count SHALL increment.
REQ-017 When the accepted sample makes count 4, the state SHALL go to HOLD and frame_valid SHALL be 1 from the next cycle.
REQ-018 Latency: frame_valid SHALL assert exactly 1 cycle after the 4th (or completing) sample handshake.
REQ-019 In HOLD, frame_valid SHALL stay 1 and x0..x3 SHALL stay stable until frame_ready is 1.
REQ-020 A frame is accepted when frame_valid and frame_ready are both 1; on acceptance:
- state SHALL go to FILL;
- frame_count SHALL increment, wrapping modulo 2^CNT_W;
- the sample register SHALL retain or discard samples per REQ-027/REQ-028.
REQ-021 frame_valid and s_ready SHALL never both be 1, so a sample and a frame are never transferred in the same cycle.
REQ-022 s_valid in HOLD SHALL be ignored; the source holds its sample per the valid/ready rule.
REQ-023 Outputs x0..x3 SHALL be direct register outputs, with no combinational path from s_re/s_im.
REQ-024 flush SHALL have priority over every other event: next cycle count=0, state=FILL, frame_valid=0, frame_count=0; a pending frame is discarded.

Reset
REQ-025 On rst_n=0, asynchronously:
- state=FILL, count=0;
- frame_valid=0, s_ready=1 once reset is released;
- frame_count=0;
- x0..x3 = all zeros.
REQ-026 Reset asserted mid-frame or in HOLD SHALL discard all partial and held data.

Configuration
REQ-027 With macro STFT_OVERLAP_EN defined: hop = 2 (50% overlap).
- On frame acceptance, old x2,x3 SHALL move to x0,x1 and count SHALL become 2.
- Each following frame therefore needs 2 new samples.
- The first frame after reset or flush still needs 4 samples.
REQ-028 Without STFT_OVERLAP_EN: hop = 4.
- On frame acceptance, count SHALL become 0 and frames SHALL be disjoint.
- x contents are don't-care until overwritten.

Verification
REQ-029 Stream samples re = 1..4 (im = 0) with frame_ready=1 -> one cycle after sample 4, frame_valid=1 with re_x0..x3 = 1,2,3,4; then frame_count=1.
REQ-030 Stream re = 1..8 with frame_ready=1:
- Without overlap -> frames (1,2,3,4) and (5,6,7,8).
- With STFT_OVERLAP_EN -> frames (1,2,3,4), (3,4,5,6), (5,6,7,8); frame_count=3.
REQ-031 Hold frame_ready=0 for 5 cycles after the frame forms -> frame_valid stays 1, x0..x3 stay stable, s_ready=0 throughout, no sample is lost when ready releases.
REQ-032 Assert flush while count=3, and separately while in HOLD -> next cycle count=0, frame_valid=0, frame_count=0; the next frame contains only post-flush samples.
REQ-033 Pulse rst_n=0 asynchronously mid-frame -> outputs zero immediately; 4 new samples produce a correct frame.
REQ-034 Preset frame_count to 2^CNT_W-1 via accepted frames (CNT_W=4 build, 15 frames) -> the 16th accepted frame wraps frame_count to 0.
